// File: rtl/opf_pkg.sv
// Shared defaults and enums for the operand fetch stage.
// The optional write-bypass path is enabled with macro OPF_WBYPASS_EN.
package opf_pkg;

    localparam int OPF_DATA_W = 16;
    localparam int OPF_NREGS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        HOLD = 2'd3
    } opf_state_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_t;

endpackage

// File: rtl/regfile8x16.sv
// Register file: one synchronous write port, one combinational read port,
// every entry cleared asynchronously by rst_n.
module regfile8x16
    import opf_pkg::*;
#(
    parameter int DATA_W = OPF_DATA_W,
    parameter int NREGS  = OPF_NREGS,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_num,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_num] <= wr_data;
        end
    end

    assign rd_data = regs[rd_num];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: captures a request, reads Ain then Bin over two cycles and
// holds them for the ALU. OPF_WBYPASS_EN forwards same-cycle writebacks.
module operand_fetch
    import opf_pkg::*;
#(
    parameter int DATA_W = OPF_DATA_W,
    parameter int NREGS  = OPF_NREGS,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  rn,
    input  logic [IDX_W-1:0]  rm,
    input  logic [1:0]        shift,
    input  logic [1:0]        aluop_in,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] sximm5,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_num,
    input  logic [DATA_W-1:0] wr_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic [1:0]        ALUop,
    output logic [1:0]        state_dbg
);

    // Both ports transfer on a rising edge where valid and ready are high;
    // once raised, op_valid and Ain/Bin/ALUop stay put until op_ready.
    opf_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rn_q, rm_q;
    shift_t            shift_q;
    logic              asel_q, bsel_q;
    logic [DATA_W-1:0] sximm5_q;
    logic [1:0]        aluop_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data, rd_val, shifted;

    regfile8x16 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_num  (wr_num),
        .wr_data (wr_data),
        .rd_num  (rd_idx),
        .rd_data (rd_data)
    );

    // A single read port serves Rn in RD_A and Rm in RD_B.
    assign rd_idx = (state == RD_B) ? rm_q : rn_q;

`ifdef OPF_WBYPASS_EN
    assign rd_val = (wr_en && (wr_num == rd_idx)) ? wr_data : rd_data;
`else
    assign rd_val = rd_data;
`endif

    always_comb begin
        shifted = rd_val;
        case (shift_q)
            SH_LSL1: shifted = {rd_val[DATA_W-2:0], 1'b0};
            SH_LSR1: shifted = {1'b0, rd_val[DATA_W-1:1]};
            SH_ASR1: shifted = {rd_val[DATA_W-1], rd_val[DATA_W-1:1]};
            default: shifted = rd_val;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = HOLD;
            HOLD:    if (op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= SH_NONE;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            sximm5_q <= '0;
            aluop_q  <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                rn_q     <= rn;
                rm_q     <= rm;
                shift_q  <= shift_t'(shift);
                asel_q   <= asel;
                bsel_q   <= bsel;
                sximm5_q <= sximm5;
                aluop_q  <= aluop_in;
            end
            if (state == RD_A) a_q <= asel_q ? '0 : rd_val;
            if (state == RD_B) b_q <= bsel_q ? sximm5_q : shifted;
        end
    end

    assign req_ready = (state == IDLE);
    assign op_valid  = (state == HOLD);
    assign Ain       = a_q;
    assign Bin       = b_q;
    assign ALUop     = aluop_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hand-written
// bypass, HOLD stall and mid-request reset sequences.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  rn, rm;
    logic [1:0]  shift, aluop_in;
    logic        asel, bsel;
    logic [15:0] sximm5;
    logic        wr_en;
    logic [2:0]  wr_num;
    logic [15:0] wr_data;
    logic        op_valid, op_ready;
    logic [15:0] Ain, Bin;
    logic [1:0]  ALUop;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [33:0] exp_q[$];

    typedef struct {
        logic [2:0]  rn, rm;
        logic [1:0]  sh, op;
        logic        asel, bsel;
        logic [15:0] imm, ea, eb;
    } vec_t;

    vec_t vecs[8];

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rn        (rn),
        .rm        (rm),
        .shift     (shift),
        .aluop_in  (aluop_in),
        .asel      (asel),
        .bsel      (bsel),
        .sximm5    (sximm5),
        .wr_en     (wr_en),
        .wr_num    (wr_num),
        .wr_data   (wr_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] n, input logic [15:0] d);
        wr_en = 1'b1; wr_num = n; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [1:0] a_sh,
                         input logic [1:0] a_op, input logic a_asel, input logic a_bsel,
                         input logic [15:0] a_imm, input logic [15:0] ea, input logic [15:0] eb);
        rn = a_rn; rm = a_rm; shift = a_sh; aluop_in = a_op;
        asel = a_asel; bsel = a_bsel; sximm5 = a_imm;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("accept_ready_low", req_ready, 0);
        exp_q.push_back({a_op, ea, eb});
    endtask

    task automatic wait_valid(input int exp_n);
        int n = 0;
        while (!op_valid && n < 10) begin
            tick();
            n++;
        end
        chk("latency", n, exp_n);
    endtask

    task automatic check_ops(input string tag);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ain"}, Ain, e[31:16]);
            chk({tag, "_bin"}, Bin, e[15:0]);
            chk({tag, "_aluop"}, ALUop, e[33:32]);
        end
    endtask

    task automatic handshake();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        chk("post_hs_op_valid", op_valid, 0);
        chk("post_hs_req_ready", req_ready, 1);
    endtask

    initial begin
        vecs[0] = '{3'd3, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1234};
        vecs[1] = '{3'd3, 3'd5, 2'b01, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0002};
        vecs[2] = '{3'd5, 3'd5, 2'b10, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h8001, 16'h4000};
        vecs[3] = '{3'd1, 3'd5, 2'b11, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h00FF, 16'hC000};
        vecs[4] = '{3'd3, 3'd3, 2'b00, 2'b10, 1'b1, 1'b1, 16'hFFF0, 16'h0000, 16'hFFF0};
        vecs[5] = '{3'd7, 3'd1, 2'b11, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h7FFE, 16'h007F};
        vecs[6] = '{3'd0, 3'd7, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFC};
        vecs[7] = '{3'd7, 3'd7, 2'b10, 2'b11, 1'b1, 1'b0, 16'h1111, 16'h0000, 16'h3FFF};

        rst_n = 1'b0; req_valid = 1'b0; op_ready = 1'b0;
        rn = '0; rm = '0; shift = '0; aluop_in = '0; asel = 1'b0; bsel = 1'b0;
        sximm5 = '0; wr_en = 1'b0; wr_num = '0; wr_data = '0;
        #1;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_ain", Ain, 0);
        chk("rst_bin", Bin, 0);
        chk("rst_aluop", ALUop, 0);
        chk("rst_state", state_dbg, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("rel_req_ready", req_ready, 1);
        tick();

        wr_reg(3'd3, 16'h1234);
        wr_reg(3'd5, 16'h8001);
        wr_reg(3'd1, 16'h00FF);
        wr_reg(3'd7, 16'h7FFE);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].rn, vecs[i].rm, vecs[i].sh, vecs[i].op, vecs[i].asel,
                  vecs[i].bsel, vecs[i].imm, vecs[i].ea, vecs[i].eb);
            wait_valid(2);
            check_ops($sformatf("vec%0d", i));
            handshake();
        end

        // Writeback to Rn during the RD_A cycle.
        wr_reg(3'd2, 16'h0001);
`ifdef OPF_WBYPASS_EN
        issue(3'd2, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'h0000);
`else
        issue(3'd2, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000);
`endif
        wr_en = 1'b1; wr_num = 3'd2; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        wait_valid(1);
        check_ops("bypass");
        handshake();
        issue(3'd2, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 16'hBEEF);
        wait_valid(2);
        check_ops("after_bypass");
        handshake();

        // HOLD stalled while the source register is rewritten.
        wr_reg(3'd4, 16'h1111);
        issue(3'd4, 3'd4, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h1111, 16'h1111);
        wait_valid(2);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_num = 3'd4; wr_data = 16'h2000 + 16'(i);
            tick();
            chk("stall_op_valid", op_valid, 1);
            chk("stall_ain", Ain, 16'h1111);
            chk("stall_bin", Bin, 16'h1111);
        end
        wr_en = 1'b0;
        check_ops("stall");
        handshake();
        issue(3'd4, 3'd4, 2'b11, 2'b10, 1'b0, 1'b0, 16'h0000, 16'h2004, 16'h1002);
        wait_valid(2);
        check_ops("after_stall");
        handshake();

        // Reset pulse while in RD_B aborts the request.
        issue(3'd3, 3'd5, 2'b00, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h8001);
        tick();
        chk("pre_rst_state", state_dbg, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state_dbg, 0);
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_ain", Ain, 0);
        chk("mid_rst_bin", Bin, 0);
        chk("mid_rst_aluop", ALUop, 0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        #1;
        chk("mid_rel_req_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("aborted_op_valid", op_valid, 0);
        end
        chk("aborted_state", state_dbg, 0);
        for (int i = 0; i < 4; i++) begin
            issue(3'(2 * i), 3'(2 * i + 1), 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
            wait_valid(2);
            check_ops($sformatf("cleared%0d", i));
            handshake();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
